riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 Parameter XLEN, default 32, data width in bits; legal values 32 and 64.
REQ-002 Parameter AW, default 32, byte-address width.
REQ-003 Derived constant BE_W = XLEN/8, the number of byte lanes.
REQ-004 clk  in  1  single clock for all state; the block has one clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_valid  in  1  core presents a load/store request.
REQ-007 o_ready  out  1  LSU accepts a request this cycle.
REQ-008 i_we  in  1  1 = store, 0 = load.
REQ-009 i_funct3  in  3  RISC-V load/store funct3.
REQ-010 i_addr  in  AW  byte address.
REQ-011 i_wdata  in  XLEN  store data, right-aligned.
REQ-012 o_rvalid  out  1  one-cycle pulse marking completion of a load or store.
REQ-013 o_rdata  out  XLEN  load result, extended; 0 for stores.
REQ-014 o_misalign  out  1  one-cycle pulse marking a misaligned or illegal access.
REQ-015 o_busy  out  1  transaction in flight; the core must stall.
REQ-016 o_bus_req, o_bus_we  out  1 each  bus request and write flag.
REQ-017 o_bus_addr  out  AW  bus address, aligned to XLEN/8 bytes.
REQ-018 o_bus_be  out  BE_W  bus byte enables.
REQ-019 o_bus_wdata  out  XLEN  lane-shifted store data.
REQ-020 i_bus_gnt  in  1  bus accepts the request this cycle.
REQ-021 i_bus_rvalid  in  1  bus response valid.
REQ-022 i_bus_rdata  in  XLEN  bus read data.

Function
REQ-023 The FSM shall have states IDLE, REQ, RESP.
- IDLE: o_ready=1.
- On i_valid, latch we, funct3, address low bits and lane-shifted data.
- Legal access: go to REQ.
- Misaligned or illegal access: stay IDLE and pulse o_misalign next cycle.
REQ-024 In REQ, o_bus_req=1 and all bus outputs shall hold stable until i_bus_gnt; on grant go to RESP.
REQ-025 In RESP, wait for i_bus_rvalid, then pulse o_rvalid with o_rdata and return to IDLE; stores also wait for i_bus_rvalid as the write ack.
REQ-026 Latency with zero-wait gnt and rvalid: accept in cycle N, o_bus_req in N+1, o_rvalid in N+2 if rvalid arrives in N+2.
REQ-027 o_ready=0 and o_busy=1 in REQ and RESP; i_valid is ignored there.
REQ-028 Legal funct3: 000, 001, 010, 100, 101; when XLEN=64, also 011 (LD/SD) and 110 (LWU). All other codes are illegal.
REQ-029 Alignment: a halfword needs addr[0]=0, a word needs addr[1:0]=0, a doubleword needs addr[2:0]=0.
REQ-030 Byte enables shall be the access-size mask shifted left by addr[log2(BE_W)-1:0]; o_bus_wdata shall be i_wdata replicated or shifted into the same lanes.
REQ-031 Load extraction shall shift i_bus_rdata right by the latched lane offset, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to XLEN.
REQ-032 i_bus_rvalid arriving in the same cycle as i_bus_gnt shall be ignored; a response counts only in RESP.
REQ-033 o_rdata shall hold its last load value until the next completion.

Reset
REQ-034 Asynchronous assertion of rst_n shall force: state=IDLE, o_rvalid=0, o_misalign=0, o_rdata=0, o_bus_req=0, o_bus_be=0, o_bus_addr=0, o_bus_wdata=0.
REQ-035 Reset mid-transaction shall abandon it without any o_rvalid; the first accept is possible in the first cycle after deassertion.

Configuration
REQ-036 Macro RISCV_LSU_MISALIGN_EXC_EN controls misaligned handling.
- Defined: misaligned access behaves per REQ-023.
- Undefined: o_misalign is tied 0, and a misaligned access completes with o_rvalid one cycle after accept, o_rdata=0 and no bus traffic; illegal funct3 behaves the same way.

Structure
REQ-037 Package riscv_lsu_pkg shall hold:
- the FSM state enum;
- funct3 localparams (LB, LH, LW, LD, LBU, LHU, LWU);
- the function computing the size mask from funct3.
REQ-038 The load aligner/extender shall be the combinational sub-module riscv_lsu_align.

Verification
REQ-039 XLEN=32, LB at 0x103, bus rdata 0x80FF_FF00 -> o_rdata 0xFFFF_FF80, o_bus_be 4'b1000, o_bus_addr 0x100.
REQ-040 XLEN=32, SH at 0x22 with wdata 0x1234 -> o_bus_be 4'b1100, o_bus_wdata 0x1234_xxxx, upper half 0x1234.
REQ-041 XLEN=64, LWU at 0x4, rdata 0x8765_4321_0000_0000 -> o_rdata 0x0000_0000_8765_4321.
REQ-042 LW at 0x2 with macro defined -> o_misalign pulse, no o_bus_req; same case without the macro -> o_rvalid with o_rdata=0.
REQ-043 gnt held low for 3 cycles -> bus outputs stable, o_busy=1, and a new i_valid is ignored.
REQ-044 rst_n pulled low during RESP -> o_bus_req=0, no o_rvalid; a new LW is accepted cleanly after release.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: FSM states, load/store funct3 codes and the access-size byte mask helper.
package riscv_lsu_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 8'h01 : f3[1:0] == 2'b01 ? 8'h03 : f3[1:0] == 2'b10 ? 8'h0F : 8'hFF;
    endfunction
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: shifts bus read data down by the lane offset and sign/zero-extends it.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = 2
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [OW-1:0]   i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);
    localparam int BE_W = XLEN / 8;
    logic [XLEN-1:0] w_sh, w_mask, w_top;
    logic [BE_W-1:0] w_bm;
    logic w_sign;
    assign w_sh = i_rdata >> {i_off, 3'b000};
    assign w_bm = BE_W'(size_mask(i_funct3));
    for (genvar g = 0; g < BE_W; g++) begin : g_mask
        assign w_mask[8*g +: 8] = {8{w_bm[g]}};
    end
    // w_top isolates the most significant bit of the accessed field
    assign w_top  = w_mask & ~(w_mask >> 1);
    assign w_sign = ~i_funct3[2] & |(w_sh & w_top);
    assign o_data = (w_sh & w_mask) | ({XLEN{w_sign}} & ~w_mask);
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding RISC-V load/store unit; define RISCV_LSU_MISALIGN_EXC_EN to report bad accesses on o_misalign.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_we,
    input  logic [2:0]          i_funct3,
    input  logic [AW-1:0]       i_addr,
    input  logic [XLEN-1:0]     i_wdata,
    output logic                o_rvalid,
    output logic [XLEN-1:0]     o_rdata,
    output logic                o_misalign,
    output logic                o_busy,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [AW-1:0]       o_bus_addr,
    output logic [XLEN/8-1:0]   o_bus_be,
    output logic [XLEN-1:0]     o_bus_wdata,
    input  logic                i_bus_gnt,
    input  logic                i_bus_rvalid,
    input  logic [XLEN-1:0]     i_bus_rdata
);
    localparam int BE_W = XLEN / 8;
    localparam int OW   = $clog2(BE_W);
    state_t r_state;
    logic r_we, r_flag;
    logic [2:0] r_f3, w_amask;
    logic [OW-1:0] r_off, w_off;
    logic [XLEN-1:0] r_rdata, w_ld;
    logic w_legal, w_bad, w_acc, w_done;
    assign w_off   = i_addr[OW-1:0];
    assign w_amask = 3'((4'd1 << i_funct3[1:0]) - 4'd1);
    assign w_legal = i_funct3 inside {LB, LH, LW, LBU, LHU} || (XLEN == 64 && i_funct3 inside {LD, LWU});
    assign w_bad   = !w_legal || |(w_off & w_amask[OW-1:0]);
    assign w_acc   = i_valid && r_state == S_IDLE;
    assign w_done  = r_state == S_RESP && i_bus_rvalid;
    assign o_ready = r_state == S_IDLE;
    assign o_busy  = r_state != S_IDLE;
    assign o_rdata = w_done ? (r_we ? '0 : w_ld) : r_rdata;
`ifdef RISCV_LSU_MISALIGN_EXC_EN
    assign o_misalign = r_flag;
    assign o_rvalid   = w_done;
`else
    assign o_misalign = 1'b0;
    assign o_rvalid   = w_done | r_flag;
`endif
    riscv_lsu_align #(.XLEN(XLEN), .OW(OW)) u_align (
        .i_rdata  (i_bus_rdata),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_data   (w_ld)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_f3        <= LB;
            r_off       <= '0;
            r_flag      <= 1'b0;
            r_rdata     <= '0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_be    <= '0;
            o_bus_wdata <= '0;
        end else begin
            r_flag <= 1'b0;
            case (r_state)
                S_IDLE: if (w_acc) begin
                    r_we  <= i_we;
                    r_f3  <= i_funct3;
                    r_off <= w_off;
                    if (w_bad) begin
                        r_flag <= 1'b1;
`ifndef RISCV_LSU_MISALIGN_EXC_EN
                        r_rdata <= '0;
`endif
                    end else begin
                        r_state     <= S_REQ;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_we;
                        o_bus_addr  <= {i_addr[AW-1:OW], OW'(0)};
                        o_bus_be    <= BE_W'(size_mask(i_funct3)) << w_off;
                        o_bus_wdata <= i_wdata << {w_off, 3'b000};
                    end
                end
                S_REQ: if (i_bus_gnt) begin
                    o_bus_req <= 1'b0;
                    r_state   <= S_RESP;
                end
                S_RESP: if (i_bus_rvalid) begin
                    r_state <= S_IDLE;
                    r_rdata <= r_we ? '0 : w_ld;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed and random load/store transactions against a byte-level reference model.
module tb_riscv_lsu;
    logic clk = 0, rst_n = 0;
    logic valid = 0, we = 0, gnt = 0, brv = 0;
    logic [2:0] f3 = 0;
    logic [31:0] addr = 0, wdata = 0, rdata_bus = 0;
    logic o_ready, o_rvalid, o_misalign, o_busy, o_bus_req, o_bus_we;
    logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
    logic [3:0] o_bus_be;
    logic v_valid = 0, v_gnt = 0, v_brv = 0;
    logic [2:0] v_f3 = 0;
    logic [31:0] v_addr = 0;
    logic [63:0] v_rdata_bus = 0;
    logic v_ready, v_rvalid, v_misalign, v_busy, v_bus_req, v_bus_we;
    logic [63:0] v_rdata, v_bus_wdata;
    logic [31:0] v_bus_addr;
    logic [7:0] v_bus_be;
    int checks = 0, errors = 0;
    logic [3:0] last_be;
    logic [31:0] last_addr, last_wdata;

    always #5 clk = ~clk;

    riscv_lsu #(.XLEN(32), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(valid), .o_ready(o_ready), .i_we(we), .i_funct3(f3),
        .i_addr(addr), .i_wdata(wdata), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_misalign(o_misalign),
        .o_busy(o_busy), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata), .i_bus_gnt(gnt), .i_bus_rvalid(brv),
        .i_bus_rdata(rdata_bus)
    );

    riscv_lsu #(.XLEN(64), .AW(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .i_valid(v_valid), .o_ready(v_ready), .i_we(1'b0), .i_funct3(v_f3),
        .i_addr(v_addr), .i_wdata(64'h0), .o_rvalid(v_rvalid), .o_rdata(v_rdata), .o_misalign(v_misalign),
        .o_busy(v_busy), .o_bus_req(v_bus_req), .o_bus_we(v_bus_we), .o_bus_addr(v_bus_addr),
        .o_bus_be(v_bus_be), .o_bus_wdata(v_bus_wdata), .i_bus_gnt(v_gnt), .i_bus_rvalid(v_brv),
        .i_bus_rdata(v_rdata_bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_bad(input logic [2:0] f, input logic [31:0] a);
        int n;
        n = 1 << f[1:0];
        return !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (a % n != 0);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [31:0] a);
        int n;
        n = 1 << f[1:0];
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int nb;
        logic [63:0] u;
        nb = 8 << f[1:0];
        u = {32'b0, d} >> (8 * (a % 4));
        u = u & ((64'd1 << nb) - 64'd1);
        if (!f[2] && u[nb-1]) u = u - (64'd1 << nb);
        return u[31:0];
    endfunction

    task automatic txn(input logic we_i, input logic [2:0] f_i, input logic [31:0] a_i,
                       input logic [31:0] wd_i, input logic [31:0] rd_i, input int gw, input int rw);
        logic [31:0] exp_ld, sh;
        logic [3:0] be;
        int off;
        exp_ld = we_i ? 32'h0 : ref_load(f_i, a_i, rd_i);
        be = ref_be(f_i, a_i);
        off = int'(a_i % 4);
        @(negedge clk);
        valid = 1; we = we_i; f3 = f_i; addr = a_i; wdata = wd_i;
        #1 chk("ready_idle", o_ready, 1);
        @(negedge clk);
        valid = 0; f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        #1;
        if (ref_bad(f_i, a_i)) begin
`ifdef RISCV_LSU_MISALIGN_EXC_EN
            chk("bad_misalign", o_misalign, 1);
            chk("bad_rvalid", o_rvalid, 0);
`else
            chk("bad_rvalid", o_rvalid, 1);
            chk("bad_rdata", o_rdata, 0);
            chk("bad_misalign", o_misalign, 0);
`endif
            chk("bad_noreq", o_bus_req, 0);
            @(negedge clk);
            #1 chk("bad_pulse_end", {o_rvalid, o_misalign, o_ready}, 3'b001);
            return;
        end
        chk("req", {o_bus_req, o_busy, o_ready, o_bus_we}, {3'b110, we_i});
        chk("bus_be", o_bus_be, be);
        chk("bus_addr", o_bus_addr, {a_i[31:2], 2'b00});
        for (int i = 0; i < 4; i++)
            if (be[i]) begin
                sh = wd_i >> (8 * (i - off));
                chk("wdata_lane", o_bus_wdata[8*i +: 8], sh[7:0]);
            end
        last_be = o_bus_be; last_addr = o_bus_addr; last_wdata = o_bus_wdata;
        repeat (gw) begin
            @(negedge clk);
            valid = 1; we = 1; f3 = 3'd2; addr = $urandom & 32'hFFFF_FFFC;
            #1 chk("stall", {o_bus_req, o_busy, o_ready, o_rvalid}, 4'b1100);
            chk("stable", {o_bus_be, o_bus_addr, o_bus_wdata}, {last_be, last_addr, last_wdata});
        end
        valid = 0; gnt = 1; brv = 1; rdata_bus = $urandom;
        #1 chk("gnt_rvalid_ignored", o_rvalid, 0);
        repeat (rw) begin
            @(negedge clk);
            gnt = 0; brv = 0;
            #1 chk("resp_wait", {o_rvalid, o_busy, o_bus_req}, 3'b010);
        end
        @(negedge clk);
        gnt = 0; brv = 1; rdata_bus = rd_i;
        #1 chk("done", o_rvalid, 1);
        chk("rdata", o_rdata, exp_ld);
        @(negedge clk);
        brv = 0; rdata_bus = $urandom;
        #1 chk("after", {o_rvalid, o_ready, o_bus_req}, 3'b010);
        chk("rdata_hold", o_rdata, exp_ld);
    endtask

    initial begin
        #12;
        chk("rst_ctrl", {o_ready, o_busy, o_rvalid, o_misalign, o_bus_req}, 5'b10000);
        chk("rst_bus", {o_bus_be, o_bus_addr, o_bus_wdata, o_rdata}, 0);
        @(negedge clk) rst_n = 1;
        txn(0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF00, 0, 0);
        chk("lb_vec_rdata", o_rdata, 32'hFFFF_FF80);
        chk("lb_vec_be", last_be, 4'b1000);
        chk("lb_vec_addr", last_addr, 32'h100);
        txn(1, 3'b001, 32'h22, 32'h1234, 32'hDEAD_BEEF, 1, 1);
        chk("sh_vec_be", last_be, 4'b1100);
        chk("sh_vec_upper", last_wdata[31:16], 16'h1234);
        txn(0, 3'b010, 32'h2, 32'h0, 32'h1111_1111, 0, 0);
        txn(0, 3'b101, 32'h1002, 32'h0, 32'h9ABC_0000, 3, 2);
        for (int k = 0; k < 40; k++) begin
            logic [2:0] rf;
            logic [31:0] ra;
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rf[1:0]) - 32'd1);
            txn(1'($urandom), rf, ra, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end
        @(negedge clk);
        valid = 1; we = 0; f3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        valid = 0; gnt = 1;
        @(negedge clk);
        gnt = 0;
        #1 chk("rst_mid_busy", o_busy, 1);
        #2 rst_n = 0; brv = 1;
        #1 chk("rst_mid", {o_bus_req, o_rvalid, o_busy}, 3'b000);
        @(posedge clk);
        #1 rst_n = 1; brv = 0;
        txn(0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 0, 0);
        @(negedge clk);
        v_valid = 1; v_f3 = 3'b110; v_addr = 32'h4;
        @(negedge clk);
        v_valid = 0;
        #1 chk("v_req", {v_bus_req, v_bus_be, v_bus_addr}, {1'b1, 8'hF0, 32'h0});
        v_gnt = 1;
        @(negedge clk);
        v_gnt = 0; v_brv = 1; v_rdata_bus = 64'h8765_4321_0000_0000;
        #1 chk("v_lwu", {v_rvalid, v_rdata}, {1'b1, 64'h0000_0000_8765_4321});
        @(negedge clk);
        v_brv = 0; v_valid = 1; v_f3 = 3'b010;
        @(negedge clk);
        v_valid = 0; v_gnt = 1;
        @(negedge clk);
        v_gnt = 0; v_brv = 1;
        #1 chk("v_lw", {v_rvalid, v_rdata}, {1'b1, 64'hFFFF_FFFF_8765_4321});
        @(negedge clk);
        v_brv = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
